// File: rtl/fifo_wr_arbiter.sv
// FIFO write-side arbiter: round-robin grant with packet lock, write pointer, wfull (+ wafull under FIFO_AFULL_EN).
// Latency: grant/w_en/waddr/wdata are combinational and commit at the same posedge; wptr/wfull/wafull are registered.
// Backpressure: gnt stays 0 while wfull=1; a LOCKED owner with req=0 stalls all other requesters.
module fifo_wr_arbiter #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4,
    parameter int NREQ     = 4,
    parameter int AFULL_TH = 2
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*DATASIZE-1:0] wdata_in,
    input  logic [ADDRSIZE:0]        wq2_rptr,
    output logic [NREQ-1:0]          gnt,
    output logic                     w_en,
    output logic [ADDRSIZE-1:0]      waddr,
    output logic [DATASIZE-1:0]      wdata,
    output logic [ADDRSIZE:0]        wptr,
    output logic                     wfull
`ifdef FIFO_AFULL_EN
    ,
    output logic                     wafull
`endif
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        r_state;
    logic [IDXW-1:0]   r_owner;
    logic [IDXW-1:0]   r_last;
    logic [ADDRSIZE:0] r_wbin;
    logic [ADDRSIZE:0] r_wptr;
    logic              r_wfull;

    logic              w_gnt_vld;
    logic [IDXW-1:0]   w_gnt_idx;
    logic [NREQ-1:0]   w_gnt;
    logic [ADDRSIZE:0] w_wbin_next;
    logic [ADDRSIZE:0] w_wgray_next;
    logic [ADDRSIZE:0] w_rptr_full;
    logic              w_full_next;

    // Reverse scan so the last hit is the first requester after r_last.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (wrst_n && !r_wfull) begin
            if (r_state == ST_LOCKED) begin
                w_gnt_vld = req[r_owner];
                w_gnt_idx = r_owner;
            end else begin
                for (int k = NREQ; k >= 1; k--) begin
                    if (req[(int'(r_last) + k) % NREQ]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = IDXW'((int'(r_last) + k) % NREQ);
                    end
                end
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_gnt_vld) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign gnt   = w_gnt;
    assign w_en  = w_gnt_vld;
    assign waddr = r_wbin[ADDRSIZE-1:0];
    assign wdata = wdata_in[int'(w_gnt_idx)*DATASIZE +: DATASIZE];
    assign wptr  = r_wptr;
    assign wfull = r_wfull;

    assign w_wbin_next  = r_wbin + (ADDRSIZE+1)'(w_en);
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign w_rptr_full = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    assign w_full_next = (w_wgray_next == w_rptr_full);

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_last  <= IDXW'(NREQ-1);
        end else begin
            r_wbin  <= w_wbin_next;
            r_wptr  <= w_wgray_next;
            r_wfull <= w_full_next;
            if (w_en) begin
                r_last <= w_gnt_idx;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_en && lock[w_gnt_idx]) begin
                        r_state <= ST_LOCKED;
                        r_owner <= w_gnt_idx;
                    end
                end
                ST_LOCKED: begin
                    if (!lock[r_owner]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_AFULL_EN
    logic [ADDRSIZE:0]   w_rbin;
    logic [ADDRSIZE:0]   w_used;
    logic [ADDRSIZE+1:0] w_free;
    logic                w_afull_next;
    logic                r_wafull;

    always_comb begin
        w_rbin[ADDRSIZE] = wq2_rptr[ADDRSIZE];
        for (int i = ADDRSIZE-1; i >= 0; i--) begin
            w_rbin[i] = w_rbin[i+1] ^ wq2_rptr[i];
        end
    end

    assign w_used       = w_wbin_next - w_rbin;
    assign w_free       = (ADDRSIZE+2)'(1 << ADDRSIZE) - {1'b0, w_used};
    assign w_afull_next = w_full_next || (w_free <= (ADDRSIZE+2)'(AFULL_TH));

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wafull <= 1'b0;
        end else begin
            r_wafull <= w_afull_next;
        end
    end

    assign wafull = r_wafull;
`endif

endmodule
